// File: rtl/fifo_rr_arbiter_pkg.sv
// Shared types and constants for the FIFO round-robin arbiter.
// Optional statistics counters are enabled with ARB_STATS_EN.
package fifo_arb_pkg;

  localparam int NUM_PORTS = 4;
  localparam int DATA_W    = 10;
  localparam int DEST_MSB  = 9;
  localparam int CNT_W     = 8;

  typedef enum logic [1:0] {
    RESET = 2'd0,
    IDLE  = 2'd1,
    ROUTE = 2'd2,
    PAUSE = 2'd3
  } arb_state_e;

  // Decode a word's destination field into an output one-hot.
  function automatic logic [NUM_PORTS-1:0] dest_onehot(
    input logic [DATA_W-1:0] word
  );
    logic [1:0] d;
    d = word[DEST_MSB -: 2];
    return 4'b0001 << d;
  endfunction

endpackage

// File: rtl/fifo_rr_arbiter_if.sv
// Handshake bundle between the arbiter and the FIFO banks.
// master is the arbiter side, slave is the FIFO bank side.
interface fifo_rr_arbiter_if;
  import fifo_arb_pkg::*;

  logic [NUM_PORTS-1:0]        in_empty;
  logic [NUM_PORTS*DATA_W-1:0] in_data;
  logic [NUM_PORTS-1:0]        in_pop;
  logic [NUM_PORTS-1:0]        out_alm_full;
  logic [NUM_PORTS-1:0]        out_push;
  logic [DATA_W-1:0]           out_data;

  modport master (
    input  in_empty,
    input  in_data,
    input  out_alm_full,
    output in_pop,
    output out_push,
    output out_data
  );

  modport slave (
    output in_empty,
    output in_data,
    output out_alm_full,
    input  in_pop,
    input  out_push,
    input  out_data
  );

endinterface

// File: rtl/fifo_rr_arbiter_rr_pick4.sv
// 4-way rotating-priority picker: first requester at or above ptr.
// Purely combinational; any flags that some request is present.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] gnt,
  output logic       any
);

  logic [1:0] idx;

  // Walk from farthest to nearest offset so the nearest wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = |req;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) gnt = 4'b0001 << idx;
    end
  end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Round-robin mover from 4 input FIFOs to 4 output FIFOs.
// Define ARB_STATS_EN to add per-output push counters (cnt_out).
module fifo_rr_arbiter
  import fifo_arb_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  fifo_rr_arbiter_if.master       bus,
  output logic [1:0]              state,
  output logic                    idle
`ifdef ARB_STATS_EN
  ,
  output logic [NUM_PORTS*CNT_W-1:0] cnt_out
`endif
);

  arb_state_e state_q;
  arb_state_e state_d;

  logic [1:0]           rr_ptr;
  logic [1:0]           sel_q;
  logic                 valid_q;
  logic [NUM_PORTS-1:0] gnt;
  logic                 pick_any;
  logic                 any_full;
  logic                 any_req;
  logic                 grant_en;
  logic [1:0]           gidx;
  logic [DATA_W-1:0]    word;

  assign any_full = |bus.out_alm_full;
  assign any_req  = |(~bus.in_empty);

  rr_pick4 u_pick (
    .req (~bus.in_empty),
    .ptr (rr_ptr),
    .gnt (gnt),
    .any (pick_any)
  );

  // Next-state decode for the routing FSM.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RESET: state_d = IDLE;
      IDLE: begin
        if (any_full)     state_d = PAUSE;
        else if (any_req) state_d = ROUTE;
      end
      ROUTE: begin
        if (any_full)      state_d = PAUSE;
        else if (!any_req) state_d = IDLE;
      end
      PAUSE: begin
        if (!any_full) state_d = any_req ? ROUTE : IDLE;
      end
      default: state_d = RESET;
    endcase
  end

  assign grant_en = !rst && (state_q == ROUTE)
                  && !any_full && pick_any;

  // Encode the one-hot grant into an input index.
  always_comb begin
    gidx = 2'd0;
    unique case (1'b1)
      gnt[0]:  gidx = 2'd0;
      gnt[1]:  gidx = 2'd1;
      gnt[2]:  gidx = 2'd2;
      gnt[3]:  gidx = 2'd3;
      default: gidx = 2'd0;
    endcase
  end

  assign bus.in_pop = grant_en ? gnt : '0;

  // State, pointer and one-word pop-to-push pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RESET;
      rr_ptr  <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= grant_en;
      if (grant_en) begin
        rr_ptr <= gidx + 2'd1;
        sel_q  <= gidx;
      end
    end
  end

  assign word = bus.in_data[sel_q*DATA_W +: DATA_W];

  assign bus.out_data = rst ? '0 : word;
  assign bus.out_push = (valid_q && !rst)
                      ? dest_onehot(word) : '0;

  assign state = state_q;
  assign idle  = !rst && (state_q == IDLE) && !valid_q;

`ifdef ARB_STATS_EN
  logic [CNT_W-1:0] cnt_q [NUM_PORTS];

  // Per-output push counters, wrapping naturally.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (rst)                  cnt_q[k] <= '0;
      else if (bus.out_push[k]) cnt_q[k] <= cnt_q[k] + 1'b1;
    end
  end

  // Flatten counters onto the output bus.
  always_comb begin
    cnt_out = '0;
    for (int k = 0; k < NUM_PORTS; k++)
      cnt_out[k*CNT_W +: CNT_W] = cnt_q[k];
  end
`endif

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Randomized bench for fifo_rr_arbiter with a transaction-level model.
// Build with ARB_STATS_EN defined to also cover the counters.
module tb_fifo_rr_arbiter;
  import fifo_arb_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] state;
  logic       idle;
`ifdef ARB_STATS_EN
  logic [NUM_PORTS*CNT_W-1:0] cnt_out;
`endif

  fifo_rr_arbiter_if bus ();

  fifo_rr_arbiter dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .state (state),
    .idle  (idle)
`ifdef ARB_STATS_EN
    ,
    .cnt_out (cnt_out)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] q [4][$];
  logic [DATA_W-1:0] dout [4];

  int                m_state;
  int                m_ptr;
  bit                m_valid;
  logic [DATA_W-1:0] m_word;
  int                m_cnt [4];

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      bus.in_empty[i] = (q[i].size() == 0);
      bus.in_data[i*DATA_W +: DATA_W] = dout[i];
    end
  endtask

  task automatic add(input int i, input logic [DATA_W-1:0] w);
    if (q[i].size() < 8) q[i].push_back(w);
    drive();
  endtask

  task automatic model_reset();
    m_state = 0;
    m_ptr   = 0;
    m_valid = 1'b0;
    for (int k = 0; k < 4; k++) m_cnt[k] = 0;
  endtask

  // One clock: check at negedge, advance model and FIFOs after posedge.
  task automatic step();
    logic [3:0] nonempty;
    logic [3:0] alm;
    logic [3:0] e_pop;
    logic [3:0] e_push;
    logic [3:0] a_pop;
    int         g;
    int         idx;
    @(negedge clk);
    for (int i = 0; i < 4; i++) nonempty[i] = (q[i].size() != 0);
    alm = bus.out_alm_full;
    g = -1;
    if (!rst && m_state == 2 && alm == 4'b0) begin
      for (int k = 0; k < 4; k++) begin
        idx = (m_ptr + k) % 4;
        if (g < 0 && nonempty[idx]) g = idx;
      end
    end
    e_pop  = (g >= 0) ? 4'(1 << g) : 4'b0;
    e_push = (!rst && m_valid)
           ? (4'b0001 << m_word[DATA_W-1 -: 2]) : 4'b0;
    check("in_pop", 64'(bus.in_pop), 64'(e_pop));
    check("out_push", 64'(bus.out_push), 64'(e_push));
    check("state", 64'(state), 64'(m_state));
    check("idle", 64'(idle),
          64'(!rst && m_state == 1 && !m_valid));
    if (rst || m_valid)
      check("out_data", 64'(bus.out_data),
            64'(rst ? '0 : m_word));
`ifdef ARB_STATS_EN
    for (int k = 0; k < 4; k++)
      check("cnt_out", 64'(cnt_out[k*CNT_W +: CNT_W]),
            64'(m_cnt[k] % 256));
`endif
    a_pop = bus.in_pop;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      for (int k = 0; k < 4; k++)
        if (e_push[k]) m_cnt[k]++;
      case (m_state)
        0: m_state = 1;
        1: m_state = (alm != 0) ? 3 : (nonempty != 0) ? 2 : 1;
        2: m_state = (alm != 0) ? 3 : (nonempty == 0) ? 1 : 2;
        default:
           m_state = (alm != 0) ? 3 : (nonempty != 0) ? 2 : 1;
      endcase
      if (g >= 0) begin
        m_ptr   = (g + 1) % 4;
        m_valid = 1'b1;
        m_word  = q[g][0];
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
    for (int i = 0; i < 4; i++)
      if (a_pop[i] && q[i].size() > 0) dout[i] = q[i].pop_front();
    drive();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int sent;
  int guard;

  initial begin
    rst = 1'b1;
    bus.out_alm_full = 4'b0;
    for (int i = 0; i < 4; i++) dout[i] = '0;
    model_reset();
    // Reset held with FIFO0 non-empty; 0x2A5 routes to output 2.
    q[0].push_back(10'h2A5);
    drive();
    @(posedge clk);
    #1;
    steps(3);
    rst = 1'b0;
    steps(6);

    // Two words in every input: strict 0,1,2,3 rotation.
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++)
        add(i, 10'($urandom));
    steps(14);

    // Back-pressure on output 1 while words are moving.
    for (int i = 0; i < 4; i++) begin
      add(i, 10'($urandom));
      add(i, 10'($urandom));
    end
    steps(3);
    bus.out_alm_full = 4'b0010;
    steps(4);
    bus.out_alm_full = 4'b0;
    steps(12);

    // Single entry in FIFO3 only.
    add(3, 10'h1C3);
    steps(6);

    // Reset the cycle after a pop.
    for (int i = 0; i < 4; i++) add(i, 10'($urandom));
    steps(3);
    rst = 1'b1;
    steps(1);
    rst = 1'b0;
    steps(10);

    // Random traffic, back-pressure and occasional reset.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 2) == 0) add(i, 10'($urandom));
      bus.out_alm_full = ($urandom_range(0, 7) == 0)
                       ? 4'($urandom) : 4'b0;
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;
    bus.out_alm_full = 4'b0;
    steps(20);

    // 300 words to output 0 after a clean reset.
    rst = 1'b1;
    steps(1);
    rst = 1'b0;
    sent  = 0;
    guard = 0;
    while ((sent < 300 || q[0].size() != 0) && guard < 2000) begin
      while (sent < 300 && q[0].size() < 8) begin
        add(0, {2'b00, 8'($urandom)});
        sent++;
      end
      step();
      guard++;
    end
    check("drain_budget", 64'(guard < 2000), 64'(1));
    steps(4);
`ifdef ARB_STATS_EN
    check("cnt_wrap", 64'(cnt_out[CNT_W-1:0]), 64'(44));
`endif
    check("final_idle", 64'(idle), 64'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
